// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
//
// Sequential packed-BCD to binary converter. A DIGITS-wide packed BCD word is
// captured on an accepted start strobe and folded MSD-first into a binary
// accumulator, one multiply-by-10-and-add per clock. Completion is reported
// with a one-cycle done pulse; any nibble above 9 forces the result to zero
// and raises the error flag.
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for in_start; outputs hold the last result
//   CONVERT | one digit consumed per clock, DIGITS clocks total
//
// Ports:
//   in_clk           : clock, all state changes on the rising edge
//   in_rst_n         : synchronous active-low reset
//   in_start         : conversion request, only sampled in IDLE
//   in_bcd_value     : packed BCD input, MSD in the top nibble
//   out_binary_value : result of the last completed conversion
//   out_busy         : high while a conversion is in progress
//   out_done         : one-cycle completion pulse
//   out_error        : last conversion contained a nibble above 9
// -----------------------------------------------------------------------------
module bcd_to_binary #(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 16
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_start,
    input  logic [4*DIGITS-1:0]    in_bcd_value,
    output logic [BIN_WIDTH-1:0]   out_binary_value,
    output logic                   out_busy,
    output logic                   out_done,
    output logic                   out_error
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t                 state;
    logic [4*DIGITS-1:0]    shift_reg;
    logic [BIN_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]       digit_cnt;
    logic                   err_sticky;

    logic [3:0]             digit;
    logic [BIN_WIDTH-1:0]   acc_next;
    logic                   err_next;

    // acc*10 as shift-and-add; invalid-digit arithmetic is discarded later.
    always_comb begin
        digit    = shift_reg[4*DIGITS-1 -: 4];
        acc_next = (acc << 3) + (acc << 1) + BIN_WIDTH'(digit);
        err_next = err_sticky | (digit > 4'd9);
    end

    // digit_cnt counts down the digits still to be consumed after the current
    // one; reaching zero marks the last digit.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state            <= IDLE;
            shift_reg        <= '0;
            acc              <= '0;
            digit_cnt        <= '0;
            err_sticky       <= 1'b0;
            out_binary_value <= '0;
            out_busy         <= 1'b0;
            out_done         <= 1'b0;
            out_error        <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_start) begin
                        shift_reg  <= in_bcd_value;
                        acc        <= '0;
                        digit_cnt  <= CNT_LOAD;
                        err_sticky <= 1'b0;
                        out_error  <= 1'b0;
                        out_busy   <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc        <= acc_next;
                    shift_reg  <= shift_reg << 4;
                    err_sticky <= err_next;
                    if (digit_cnt == '0) begin
                        out_binary_value <= err_next ? '0 : acc_next;
                        out_error        <= err_next;
                        out_done         <= 1'b1;
                        out_busy         <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        digit_cnt <= digit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    localparam int DIGITS    = 4;
    localparam int BIN_WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [4*DIGITS-1:0]  bcd;
    logic [BIN_WIDTH-1:0] bin_value;
    logic                 busy;
    logic                 done;
    logic                 error;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_start         (start),
        .in_bcd_value     (bcd),
        .out_binary_value (bin_value),
        .out_busy         (busy),
        .out_done         (done),
        .out_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: positional sum of decimal digits.
    function automatic void ref_convert(input logic [4*DIGITS-1:0] v,
                                        output int value, output bit bad);
        int pw;
        int d;
        value = 0;
        bad   = 0;
        pw    = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1;
            value += d * pw;
            pw *= 10;
        end
        if (bad) value = 0;
    endfunction

    // Transaction-level timing model: an accepted start makes the unit busy
    // for DIGITS edges, then the result lands with a done pulse.
    int  m_left = 0;
    int  m_val  = 0;
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  m_err  = 0;
    int  p_val  = 0;
    bit  p_err  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_val = 0; m_busy = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    ref_convert(bcd, p_val, p_err);
                    m_left = DIGITS;
                    m_busy = 1;
                    m_err  = 0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_busy = 0;
                    m_val  = p_val;
                    m_err  = p_err;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",  32'(busy),      32'(m_busy));
            chk("done",  32'(done),      32'(m_done));
            chk("error", 32'(error),     32'(m_err));
            chk("value", 32'(bin_value), 32'(m_val));
        end
    end

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 19);
            v[4*i +: 4] = (r < 18) ? 4'(r % 10) : 4'(10 + $urandom_range(0, 5));
        end
        return v;
    endfunction

    task automatic run_conv(input logic [15:0] v, input logic [15:0] exp_val, input bit exp_err);
        @(negedge clk);
        start = 1'b1;
        bcd   = v;
        @(negedge clk);
        start = 1'b0;
        repeat (DIGITS) @(negedge clk);
        chk("dir_done",  32'(done),      32'd1);
        chk("dir_value", 32'(bin_value), 32'(exp_val));
        chk("dir_error", 32'(error),     32'(exp_err));
    endtask

    initial begin
        int  dcount;
        int  mv;
        bit  me;

        rst_n = 1'b0;
        start = 1'b0;
        bcd   = '0;

        // Pin the reference conversion with hand-computed values.
        ref_convert(16'h1234, mv, me);
        chk("model_1234", 32'(mv), 32'd1234);
        ref_convert(16'h9999, mv, me);
        chk("model_9999", 32'(mv), 32'd9999);
        ref_convert(16'h12A4, mv, me);
        chk("model_bad",  32'(me), 32'd1);

        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("rst_value", 32'(bin_value), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        rst_n = 1'b1;

        run_conv(16'h1234, 16'h04D2, 1'b0);
        run_conv(16'h9999, 16'h270F, 1'b0);
        run_conv(16'h0000, 16'h0000, 1'b0);
        run_conv(16'h0001, 16'h0001, 1'b0);
        run_conv(16'h1000, 16'h03E8, 1'b0);
        run_conv(16'h12A4, 16'h0000, 1'b1);
        run_conv(16'h0042, 16'h002A, 1'b0);

        // Second request during busy must be dropped.
        @(negedge clk);
        start = 1'b1; bcd = 16'h0777;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; bcd = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        repeat (7) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("drop_count", 32'(dcount),    32'd1);
        chk("drop_value", 32'(bin_value), 32'h0309);

        // Start held high: one conversion every DIGITS+1 cycles.
        @(negedge clk);
        start = 1'b1; bcd = 16'h0100;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        start = 1'b0;
        chk("held_count", 32'(dcount),    32'd4);
        chk("held_value", 32'(bin_value), 32'h0064);
        repeat (2) @(negedge clk);

        // Reset after two digits aborts without a done pulse.
        start = 1'b1; bcd = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_value", 32'(bin_value), 32'd0);
        chk("abort_done",  32'(done),      32'd0);
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("abort_nodone", 32'(dcount), 32'd0);
        run_conv(16'h0042, 16'h002A, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 2) == 0);
            bcd   = rand_bcd();
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (DIGITS + 2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential packed-BCD to binary converter; the inverse of the team's binary-to-BCD path. It sits between keypad/display digit registers and arithmetic logic: it accepts a 4-digit packed BCD word on a start strobe, converts it MSD-first with one multiply-by-10-and-add per clock, and reports the result with a one-cycle done pulse. Invalid digits (nibble > 9) are flagged.

## Interface
- DIGITS, 4, number of BCD digits in the input word (input width 4*DIGITS)
- BIN_WIDTH, 16, result width; must satisfy 2^BIN_WIDTH > 10^DIGITS - 1 (16 covers 9999)

- in_clk  input  1  single clock; all state changes on rising edge
- in_rst_n  input  1  reset, synchronous, active-low
- in_start  input  1  conversion request; sampled only in IDLE
- in_bcd_value  input  4*DIGITS  packed BCD, MSD in [4*DIGITS-1 -: 4]; sampled with accepted in_start
- out_binary_value  output  BIN_WIDTH  last conversion result; holds until next completion
- out_busy  output  1  high while conversion in progress
- out_done  output  1  one-cycle pulse on completion
- out_error  output  1  last conversion contained a digit > 9; holds until next accepted start

## Operation
- States: IDLE, CONVERT. No other states.
- IDLE: out_busy=0. On edge with in_start=1: latch in_bcd_value into shift register, acc=0, digit counter=0, sticky error=0, out_error=0, out_busy=1, go CONVERT.
- CONVERT, each edge: take top nibble d of shift register; acc = (acc<<3) + (acc<<1) + d, truncated to BIN_WIDTH; shift register left by 4; if d > 9 set sticky error; counter++.
- On edge processing digit DIGITS-1 (last): out_binary_value = error ? 0 : new acc; out_error = error (including that digit's check); out_done=1; out_busy=0; go IDLE.
- in_start in CONVERT ignored (not queued); in_bcd_value changes after acceptance have no effect.
- Invalid digit: conversion runs full length (fixed latency), result forced to 0, out_error=1.
- acc never overflows for valid input given BIN_WIDTH rule; invalid-digit acc arithmetic is don't-care (discarded).
- out_done is a pulse: deasserted on every edge not completing a conversion.

## Timing
- Reset (in_rst_n=0 at edge): state=IDLE, out_binary_value=0, out_busy=0, out_done=0, out_error=0, acc/counter/shift register cleared. Reset dominates in_start. Reset mid-CONVERT aborts with no done pulse; out_binary_value reads 0.
- Latency: start accepted at edge N; out_busy high from N; digits processed at edges N+1..N+DIGITS; out_done=1 and result valid for cycle after edge N+DIGITS (N+4 for default), out_busy low same cycle.
- Back-to-back: in_start held high during the done cycle is accepted at edge N+DIGITS+1; throughput one conversion per DIGITS+1 cycles.
- out_binary_value changes only at completion edge or reset; stable otherwise.

## Test plan
- Reset then in_bcd_value=0x1234, in_start 1 cycle -> out_busy 4 cycles, out_done pulse 4 edges after accept, out_binary_value=0x04D2 (1234), out_error=0.
- 0x9999 -> 0x270F; 0x0000 -> 0x0000; 0x0001 -> 0x0001; 0x1000 -> 0x03E8.
- 0x12A4 (digit A) -> out_done with out_error=1, out_binary_value=0; next start with 0x0042 -> out_error cleared at accept, result 0x002A.
- in_start pulsed and in_bcd_value changed to 0x5555 during busy of 0x0777 -> single done, result 0x0309, second request dropped.
- in_start held high continuously with 0x0100 -> done every 5 cycles, result 0x0064 each time.
- in_rst_n low for 1 cycle mid-conversion (after 2 digits) -> no done pulse, out_busy=0, out_binary_value=0; subsequent start converts normally.
